timer_arbiter: RTL and testbench



---
 rtl/timer_arb_pkg.sv | 53 +++++
 rtl/timer_arbiter_rr_arbiter.sv | 48 ++++
 rtl/timer_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_timer_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the timer arbiter.
//   - state_e    : arbiter FSM states
//   - outcome_e  : how the current delay ends once the timer is disabled
//   - wb_bus_t   : Wishbone master-to-slave bundle (cyc/stb/we/sel/adr/dat)
//   - wb_rsp_t   : Wishbone slave-to-master bundle (ack/err/dat)
//   - cfg_word() : builds the CFG value that enables the timer with a prescaler
package timer_arb_pkg;

  localparam logic [31:0] TIMER_ADR_DEF  = 32'h0;
  localparam logic [31:0] CFG_ADR_DEF    = 32'h4;
  localparam logic [31:0] CMP_ADR_DEF    = 32'h8;
  localparam int          ENABLE_BIT_DEF = 0;
  localparam int          PRSC_LSB_DEF   = 1;
  localparam int          PRSC_W         = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DIS,
    ST_WR_TMR,
    ST_WR_CMP,
    ST_WR_EN,
    ST_WAIT_IRQ,
    ST_WR_OFF
  } state_e;

  typedef enum logic [1:0] {
    OUT_DONE,
    OUT_OVF,
    OUT_CANCEL
  } outcome_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_bus_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_rsp_t;

  function automatic logic [31:0] cfg_word(input logic [PRSC_W-1:0] prsc,
                                           input int unsigned en_bit,
                                           input int unsigned prsc_lsb);
    cfg_word = (32'd1 << en_bit) | ({{(32-PRSC_W){1'b0}}, prsc} << prsc_lsb);
  endfunction

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
//   clk, rstn_i : clock, synchronous active-low reset
//   req_i       : request vector
//   adv_i       : a grant is being taken this cycle; pointer moves past it
//   gnt_o       : one-hot grant (zero when nothing requests)
//   gnt_idx_o   : index of the granted requester
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // candidate = (ptr + i) mod N_REQ, without a divider
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!found && req_i[cand[IW-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = cand[IW-1:0];
      end
    end
    if (found) gnt_o[gnt_idx_o] = 1'b1;
    ptr_d = ptr_q;
    if (adv_i && found)
      ptr_d = (gnt_idx_o == IW'(N_REQ-1)) ? '0 : gnt_idx_o + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one Wishbone timer among N_REQ one-shot delay requesters.
// Owner is granted round-robin; the arbiter then programs the timer
// (disable, clear, compare, enable), waits for the compare irq and
// disables the timer again before reporting back.
//   clk, rstn_i       : clock, synchronous active-low reset
//   req_i/delay_i/prsc_i : request level, compare value, prescaler per requester
//   cancel_i          : abort, only the current owner's bit matters
//   busy_o/done_o/err_o  : owner indicator, completion pulse, error pulse
//   irq_i             : [0] compare, [1] overflow
//   wb_bus_o/wb_bus_i : Wishbone master port (writes only)
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_IDLE     | no owner; grants on any request
// ST_WR_DIS   | write CFG = 0
// ST_WR_TMR   | write TIMER = 0
// ST_WR_CMP   | write CMP = latched delay
// ST_WR_EN    | write CFG = enable | prescaler
// ST_WAIT_IRQ | timer running, wait for compare/overflow/cancel
// ST_WR_OFF   | write CFG = 0, then report outcome
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int          N_REQ       = 4,
  parameter logic [31:0] TIMER_ADR   = TIMER_ADR_DEF,
  parameter logic [31:0] CFG_ADR     = CFG_ADR_DEF,
  parameter logic [31:0] CMP_ADR     = CMP_ADR_DEF,
  parameter int          ENABLE_BIT  = ENABLE_BIT_DEF,
  parameter int          PRSC_LSB    = PRSC_LSB_DEF,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*32-1:0]     delay_i,
  input  logic [N_REQ*PRSC_W-1:0] prsc_i,
  input  logic [N_REQ-1:0]        cancel_i,
  output logic [N_REQ-1:0]        busy_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  input  logic [1:0]              irq_i,
  output wb_bus_t                 wb_bus_o,
  input  wb_rsp_t                 wb_bus_i
);

  localparam int             IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int             TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  outcome_e            outcome_q, outcome_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [31:0]         delay_q, delay_d;
  logic [PRSC_W-1:0]   prsc_q, prsc_d;
  logic [N_REQ-1:0]    busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                cancel_q, cancel_d;
  logic [TW-1:0]       tmo_q, tmo_d;

  logic [N_REQ-1:0]    gnt_oh;
  logic [IW-1:0]       gnt_idx;
  logic                grant;
  logic                in_wr, term, berr, tmo_hit, own_cancel;
  logic                unused_dat;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .req_i     (req_i),
    .adv_i     (grant),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign in_wr      = state_q inside {ST_WR_DIS, ST_WR_TMR, ST_WR_CMP, ST_WR_EN, ST_WR_OFF};
  assign term       = in_wr & (wb_bus_i.ack | wb_bus_i.err);
  assign berr       = in_wr & wb_bus_i.err;
  assign tmo_hit    = in_wr & ~term & (tmo_q == '0);
  assign own_cancel = cancel_i[owner_q];
  assign unused_dat = ^wb_bus_i.dat;

  always_comb begin
    state_d   = state_q;
    outcome_d = outcome_q;
    owner_d   = owner_q;
    delay_d   = delay_q;
    prsc_d    = prsc_q;
    busy_d    = busy_q;
    done_d    = '0;
    err_d     = '0;
    cancel_d  = cancel_q;
    grant     = 1'b0;
    // reload on every access boundary, count down while a write stalls
    tmo_d     = (in_wr && !term && !tmo_hit) ? tmo_q - TW'(1) : TMO_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant     = 1'b1;
          owner_d   = gnt_idx;
          delay_d   = delay_i[32*int'(gnt_idx) +: 32];
          prsc_d    = prsc_i[PRSC_W*int'(gnt_idx) +: PRSC_W];
          busy_d    = gnt_oh;
          cancel_d  = 1'b0;
          outcome_d = OUT_DONE;
          state_d   = ST_WR_DIS;
        end
      end
      ST_WR_DIS, ST_WR_TMR, ST_WR_CMP, ST_WR_EN: begin
        if (berr || tmo_hit) begin
          state_d = ST_IDLE;
          busy_d  = '0;
          err_d   = busy_q;
        end else if (term) begin
          // a cancel seen during the access is honoured once it completes
          if (cancel_q || own_cancel) begin
            state_d   = ST_WR_OFF;
            outcome_d = OUT_CANCEL;
          end else begin
            case (state_q)
              ST_WR_DIS: state_d = ST_WR_TMR;
              ST_WR_TMR: state_d = ST_WR_CMP;
              ST_WR_CMP: state_d = ST_WR_EN;
              default:   state_d = ST_WAIT_IRQ;
            endcase
          end
        end else if (own_cancel) begin
          cancel_d = 1'b1;
        end
      end
      ST_WAIT_IRQ: begin
        if (own_cancel) begin
          state_d   = ST_WR_OFF;
          outcome_d = OUT_CANCEL;
        end else if (irq_i[1]) begin
          state_d   = ST_WR_OFF;
          outcome_d = OUT_OVF;
        end else if (irq_i[0]) begin
          state_d   = ST_WR_OFF;
        end
      end
      ST_WR_OFF: begin
        if (berr || tmo_hit) begin
          state_d = ST_IDLE;
          busy_d  = '0;
          err_d   = busy_q;
        end else if (term) begin
          state_d = ST_IDLE;
          busy_d  = '0;
          if (outcome_q == OUT_DONE) done_d = busy_q;
          if (outcome_q == OUT_OVF)  err_d  = busy_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      outcome_q <= OUT_DONE;
      owner_q   <= '0;
      delay_q   <= '0;
      prsc_q    <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
      cancel_q  <= 1'b0;
      tmo_q     <= TMO_LOAD;
    end else begin
      state_q   <= state_d;
      outcome_q <= outcome_d;
      owner_q   <= owner_d;
      delay_q   <= delay_d;
      prsc_q    <= prsc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cancel_q  <= cancel_d;
      tmo_q     <= tmo_d;
    end
  end

  // Bus outputs depend on registered state only
  always_comb begin
    wb_bus_o = '0;
    if (in_wr) begin
      wb_bus_o.cyc = 1'b1;
      wb_bus_o.stb = 1'b1;
      wb_bus_o.we  = 1'b1;
      wb_bus_o.sel = 4'hF;
    end
    case (state_q)
      ST_WR_DIS: wb_bus_o.adr = CFG_ADR;
      ST_WR_TMR: wb_bus_o.adr = TIMER_ADR;
      ST_WR_CMP: begin
        wb_bus_o.adr = CMP_ADR;
        wb_bus_o.dat = delay_q;
      end
      ST_WR_EN: begin
        wb_bus_o.adr = CFG_ADR;
        wb_bus_o.dat = cfg_word(prsc_q, ENABLE_BIT, PRSC_LSB);
      end
      ST_WR_OFF: wb_bus_o.adr = CFG_ADR;
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with a behavioural timer slave.
module tb_timer_arbiter;
  import timer_arb_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req = '0, cancel = '0, busy, done, err;
  logic [N*32-1:0] delay_v = '0;
  logic [N*5-1:0] prsc_v = '0;
  logic [1:0]     irq;
  logic           ovf = 1'b0;
  wb_bus_t        wbo;
  wb_rsp_t        wbi;

  timer_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rstn_i(rstn), .req_i(req), .delay_i(delay_v), .prsc_i(prsc_v),
    .cancel_i(cancel), .busy_o(busy), .done_o(done), .err_o(err),
    .irq_i(irq), .wb_bus_o(wbo), .wb_bus_i(wbi));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- timer slave model ----------------
  // mode 0: zero-wait ack, 1: error on CMP write, 2: never ack TIMER write
  int          mode = 0;
  logic [31:0] t_tmr = 0, t_cfg = 0, t_cmp = 0;
  logic        acc;
  always_comb begin
    wbi     = '0;
    wbi.ack = wbo.cyc & wbo.stb & !(mode == 2 && wbo.adr == 32'h0);
    wbi.err = wbo.cyc & wbo.stb & (mode == 1 && wbo.adr == 32'h8);
    acc     = wbi.ack & !wbi.err;
  end
  assign irq = {ovf, t_cfg[0] && (t_tmr >= t_cmp)};
  always @(posedge clk) begin
    if (t_cfg[0]) t_tmr <= t_tmr + (32'd1 << t_cfg[5:1]);
    if (acc) begin
      if (wbo.adr == 32'h0) t_tmr <= wbo.dat;
      if (wbo.adr == 32'h4) t_cfg <= wbo.dat;
      if (wbo.adr == 32'h8) t_cmp <= wbo.dat;
    end
  end

  // ---------------- scoreboard / model ----------------
  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
  typedef struct { int idx; int kind; } ev_t;   // kind 0 done, 1 err
  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  wr_cyc[$], grants[$], order[$];
  int  irq_cyc = -1, done_cyc = -1, tmr_stall = 0;
  logic irq_prev = 1'b0;
  logic [N-1:0] busy_prev = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete delay as seen on the bus: disable, clear, compare, enable, off
  task automatic push_full(input int k, input logic [31:0] d, input logic [4:0] p, input int kind);
    exp_wr.push_back('{32'h4, 32'h0});
    exp_wr.push_back('{32'h0, 32'h0});
    exp_wr.push_back('{32'h8, d});
    exp_wr.push_back('{32'h4, 32'h1 | ({27'd0, p} << 1)});
    exp_wr.push_back('{32'h4, 32'h0});
    if (kind != 2) exp_ev.push_back('{k, kind});
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic check_event(input int i, input int kind);
    ev_t e;
    if (exp_ev.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_event: got idx %0d kind %0d expected none", i, kind);
    end else begin
      e = exp_ev.pop_front();
      chk("event_idx", i, e.idx);
      chk("event_kind", kind, e.kind);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (rstn) begin
      chk("busy_onehot", $onehot0(busy), 1'b1);
      if (wbo.cyc && wbo.stb && (wbi.ack || wbi.err)) begin
        wr_cyc.push_back(cyc_cnt);
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got adr %0h dat %0h expected none", wbo.adr, wbo.dat);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_adr", wbo.adr, w.adr);
          chk("wr_dat", wbo.dat, w.dat);
          chk("wr_sel_we", {wbo.sel, wbo.we}, 5'h1F);
        end
      end
      if (wbo.cyc && wbo.adr == 32'h0 && !wbi.ack) tmr_stall++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin check_event(i, 0); done_cyc = cyc_cnt; end
        if (err[i]) check_event(i, 1);
      end
      if (irq[0] && !irq_prev) irq_cyc = cyc_cnt;
      irq_prev = irq[0];
      if (busy != '0 && busy_prev == '0)
        for (int i = 0; i < N; i++) if (busy[i]) grants.push_back(i);
      busy_prev = busy;
    end else begin
      busy_prev = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; tick(2); rstn = 1'b1;
  endtask

  task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] p);
    delay_v[k*32 +: 32] = d;
    prsc_v[k*5 +: 5]    = p;
    req[k]              = 1'b1;
  endtask

  task automatic wait_busy(input int k);
    int n = 0;
    while (!busy[k] && n < 100) begin tick(1); n++; end
    chk("wait_busy", busy[k], 1'b1);
    req[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy != '0 && n < 2000) begin tick(1); n++; end
    chk("wait_idle", busy == '0, 1'b1);
  endtask

  task automatic run_txn(input int k, input logic [31:0] d, input logic [4:0] p);
    set_req(k, d, p); wait_busy(k); wait_idle(); tick(2);
  endtask

  initial begin
    int t0, ptr, k, n;
    int lit_order[5] = '{0, 1, 2, 3, 0};
    tick(3);
    chk("reset_outputs", {busy, done, err}, 12'h0);
    chk("reset_bus", {wbo.cyc, wbo.stb, wbo.we, wbo.sel}, 7'h0);
    do_reset();

    // single request, delay 10, prsc 0: exact cycle positions
    push_full(0, 10, 0, 0);
    wr_cyc.delete();
    t0 = cyc_cnt;
    run_txn(0, 10, 0);
    chk("t1_nwrites", wr_cyc.size(), 5);
    if (wr_cyc.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("t1_wr_cycle", wr_cyc[i] - t0, i + 1);
      chk("t1_off_cycle", wr_cyc[4] - t0, 16);
    end
    chk("t1_irq_cycle", irq_cyc - t0, 15);
    chk("t1_done_cycle", done_cyc - t0, 17);

    // all four requesting: round-robin order from a fresh pointer
    do_reset();
    ptr = 0; order.delete();
    for (int i = 0; i < 5; i++) begin
      k = rr_pick(ptr, 4'hF);
      order.push_back(k);
      ptr = (k + 1) % N;
      push_full(k, 2, 0, 0);
    end
    for (int i = 0; i < 5; i++) chk("rr_model", order[i], lit_order[i]);
    grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 2, 0);
    n = 0;
    while (grants.size() < 5 && n < 300) begin tick(1); n++; end
    req = '0;
    chk("rr_grant_count", grants.size(), 5);
    wait_idle(); tick(2);
    if (grants.size() == 5)
      for (int i = 0; i < 5; i++) chk("rr_grant", grants[i], order[i]);

    // prescaler 2, delay 8
    push_full(2, 8, 2, 0);
    wr_cyc.delete();
    run_txn(2, 8, 2);
    if (wr_cyc.size() == 5) chk("prsc_irq_after_en", irq_cyc - (wr_cyc[3] + 1), 2);
    chk("prsc_done_after_irq", done_cyc - irq_cyc, 2);

    // zero delay
    push_full(1, 0, 0, 0);
    run_txn(1, 0, 0);

    // bus error on CMP write, then another requester proceeds
    mode = 1;
    exp_wr.push_back('{32'h4, 32'h0});
    exp_wr.push_back('{32'h0, 32'h0});
    exp_wr.push_back('{32'h8, 32'd7});
    exp_ev.push_back('{1, 1});
    set_req(1, 7, 0); wait_busy(1); wait_idle();
    chk("berr_pulse", err, 4'b0010);
    chk("berr_cyc_low", wbo.cyc, 1'b0);
    mode = 0;
    tick(2);
    push_full(3, 3, 1, 0);
    run_txn(3, 3, 1);

    // no ack on TIMER write: timeout
    mode = 2;
    tmr_stall = 0;
    exp_wr.push_back('{32'h4, 32'h0});
    exp_ev.push_back('{0, 1});
    set_req(0, 5, 0); wait_busy(0); wait_idle();
    chk("tmo_err_pulse", err, 4'b0001);
    chk("tmo_cyc_low", wbo.cyc, 1'b0);
    chk("tmo_cycles", tmr_stall, 16);
    mode = 0;
    tick(2);

    // overflow irq -> disable, then err
    push_full(2, 1000, 0, 1);
    set_req(2, 1000, 0); wait_busy(2);
    tick(10); ovf = 1'b1; tick(1); ovf = 1'b0;
    wait_idle(); tick(2);

    // cancel by owner during wait (non-owner cancel ignored first)
    push_full(3, 100, 0, 2);
    set_req(3, 100, 0); wait_busy(3);
    tick(5); cancel[0] = 1'b1; tick(1); cancel[0] = 1'b0;
    chk("cancel_nonowner_ignored", busy, 4'b1000);
    tick(6); cancel[3] = 1'b1; tick(1); cancel[3] = 1'b0;
    wait_idle(); tick(3);
    chk("cancel_no_pulse", {done, err}, 8'h0);

    // reset during the CMP write
    exp_wr.push_back('{32'h4, 32'h0});
    exp_wr.push_back('{32'h0, 32'h0});
    set_req(0, 5, 0); wait_busy(0);
    n = 0;
    while (!(wbo.cyc && wbo.adr == 32'h8) && n < 50) begin tick(1); n++; end
    chk("reach_wr_cmp", wbo.adr, 32'h8);
    rstn = 1'b0; tick(1);
    chk("rst_status", {busy, done, err}, 12'h0);
    chk("rst_bus_ctl", {wbo.cyc, wbo.stb, wbo.we, wbo.sel}, 7'h0);
    chk("rst_bus_adr_dat", {wbo.adr, wbo.dat}, 64'h0);
    rstn = 1'b1; tick(3);

    chk("writes_drained", exp_wr.size(), 0);
    chk("events_drained", exp_ev.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
